// File: rtl/led_pwm_dimmer.sv
// Four-button LED dimmer: debounced count/brightness buttons drive a pattern counter and a PWM duty level.
// Define LED_BREATHE_EN to add the automatic triangle "breathing" ramp of the duty level.
module led_pwm_dimmer #(
  parameter int N_LED           = 4,
  parameter int PWM_PERIOD      = 200,
  parameter int N_LEVELS        = 5,
  parameter int LVL_W           = 3,
  parameter int MIN_HIGH        = 10,
  parameter int DEBOUNCE_CYCLES = 150,
  parameter int BREATHE_STEP    = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       usr_btn,
  input  logic             breathe,
  output logic [N_LED-1:0] usr_led,
  output logic             pwm_out,
  output logic [N_LED-1:0] led_count,
  output logic [LVL_W-1:0] duty_level
);

  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(N_LEVELS - 1);

  logic [3:0]    sync1, sync2, stable, press;
  logic [DW-1:0] mis_cnt [4];
  logic [CW-1:0] pwm_cnt, active_high;
  logic [CW-1:0] high_tbl [N_LEVELS];
  logic          period_end;

  // High-time table is pure constants; level 0 gets a floor so the LEDs never go fully dark.
  for (genvar g = 0; g < N_LEVELS; g++) begin : g_tbl
    localparam int H = (g == 0) ? MIN_HIGH : (PWM_PERIOD * g) / (N_LEVELS - 1);
    assign high_tbl[g] = CW'(H);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int b = 0; b < 4; b++) mis_cnt[b] <= '0;
    end else begin
      sync1 <= usr_btn;
      sync2 <= sync1;
      press <= '0;
      for (int b = 0; b < 4; b++) begin
        if (sync2[b] == stable[b]) begin
          mis_cnt[b] <= '0;
        end else if (mis_cnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          mis_cnt[b] <= '0;
          stable[b]  <= sync2[b];
          press[b]   <= sync2[b];
        end else begin
          mis_cnt[b] <= mis_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      led_count <= '0;
    end else if (press[1] && !press[0] && led_count != '1) begin
      led_count <= led_count + 1'b1;
    end else if (press[0] && !press[1] && led_count != '0) begin
      led_count <= led_count - 1'b1;
    end
  end

  assign period_end = (pwm_cnt == CW'(PWM_PERIOD - 1));

`ifdef LED_BREATHE_EN
  localparam int SW = $clog2(BREATHE_STEP + 1);
  logic          breathe_q, dir_up;
  logic [SW-1:0] step_cnt;
`else
  logic unused_breathe;
  localparam int unused_breathe_step = BREATHE_STEP;
  assign unused_breathe = breathe;
`endif

  // While breathing, the ramp owns duty_level and the brightness buttons are ignored.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      duty_level <= TOP_LVL;
`ifdef LED_BREATHE_EN
      breathe_q  <= 1'b0;
      dir_up     <= 1'b1;
      step_cnt   <= '0;
`endif
    end else begin
`ifdef LED_BREATHE_EN
      breathe_q <= breathe;
      if (breathe) begin
        if (!breathe_q) begin
          dir_up   <= 1'b1;
          step_cnt <= '0;
        end else if (period_end) begin
          if (step_cnt == SW'(BREATHE_STEP - 1)) begin
            step_cnt <= '0;
            if (dir_up) begin
              if (duty_level == TOP_LVL) begin
                dir_up     <= 1'b0;
                duty_level <= duty_level - 1'b1;
              end else begin
                duty_level <= duty_level + 1'b1;
              end
            end else begin
              if (duty_level == '0) begin
                dir_up     <= 1'b1;
                duty_level <= duty_level + 1'b1;
              end else begin
                duty_level <= duty_level - 1'b1;
              end
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
      end else
`endif
      if (press[3] && !press[2] && duty_level != TOP_LVL) begin
        duty_level <= duty_level + 1'b1;
      end else if (press[2] && !press[3] && duty_level != '0) begin
        duty_level <= duty_level - 1'b1;
      end
    end
  end

  // active_high only reloads at the period boundary so a level change never creates a runt pulse.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      pwm_cnt     <= '0;
      active_high <= CW'(PWM_PERIOD);
      pwm_out     <= 1'b0;
    end else begin
      pwm_out <= (pwm_cnt < active_high);
      if (period_end) begin
        pwm_cnt     <= '0;
        active_high <= high_tbl[duty_level];
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  assign usr_led = led_count & {N_LED{pwm_out}};

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Scoreboard bench for led_pwm_dimmer: button presses push expected {led_count, duty_level}, checked after each press.
// Breathing checks run only when LED_BREATHE_EN is defined.
module tb_led_pwm_dimmer;

  localparam int NL = 4, PER = 200, NLEV = 5, LW = 3, MINH = 10, DEB = 150, BSTEP = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    usr_btn = '0;
  logic          breathe = 1'b0;
  logic [NL-1:0] usr_led, led_count;
  logic          pwm_out;
  logic [LW-1:0] duty_level;

  led_pwm_dimmer #(
    .N_LED(NL), .PWM_PERIOD(PER), .N_LEVELS(NLEV), .LVL_W(LW),
    .MIN_HIGH(MINH), .DEBOUNCE_CYCLES(DEB), .BREATHE_STEP(BSTEP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .usr_btn(usr_btn), .breathe(breathe),
    .usr_led(usr_led), .pwm_out(pwm_out), .led_count(led_count), .duty_level(duty_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [NL-1:0]    m_led = '0;
  logic [LW-1:0]    m_lvl = LW'(NLEV - 1);
  logic [NL+LW-1:0] sb_q[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Model the effect of one button action, queue the expected state, then drive and release.
  task automatic applyStimulus(input logic [3:0] btns, input int hold);
    if (hold >= DEB) begin
      if (btns[1] && !btns[0] && m_led != 4'hF) m_led = m_led + 1'b1;
      else if (btns[0] && !btns[1] && m_led != 4'h0) m_led = m_led - 1'b1;
      if (btns[3] && !btns[2] && int'(m_lvl) != NLEV - 1) m_lvl = m_lvl + 1'b1;
      else if (btns[2] && !btns[3] && m_lvl != '0) m_lvl = m_lvl - 1'b1;
    end
    sb_q.push_back({m_led, m_lvl});
    usr_btn = btns;
    repeat (hold) @(negedge clk);
    usr_btn = '0;
    repeat (DEB + 20) @(negedge clk);
  endtask

  task automatic checkNext(input string tag);
    logic [NL+LW-1:0] e;
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, "_led"}, int'(led_count), int'(e[NL+LW-1:LW]));
      checkOutput({tag, "_lvl"}, int'(duty_level), int'(e[LW-1:0]));
    end
  endtask

  task automatic measureWindow(output int pwm_hi, output int led_on, output int led_off);
    pwm_hi = 0; led_on = 0; led_off = 0;
    repeat (PER) begin
      @(negedge clk);
      if (pwm_out) pwm_hi++;
      if (usr_led == m_led) led_on++;
      if (usr_led == '0) led_off++;
    end
  endtask

  task automatic waitLevelChange(input int limit, output int cycles, output bit ok);
    logic [LW-1:0] start;
    start = duty_level;
    cycles = 0;
    ok = 1'b0;
    while (cycles < limit && !ok) begin
      @(negedge clk);
      cycles++;
      if (duty_level != start) ok = 1'b1;
    end
  endtask

  initial begin
    #900us;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, hi, on, off, g, k, cyc;
    bit ok;

    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_led", int'(led_count), 0);
    checkOutput("rst_lvl", int'(duty_level), NLEV - 1);
    checkOutput("rst_pwm", int'(pwm_out), 0);
    checkOutput("rst_usr_led", int'(usr_led), 0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // First up press also measures press-to-update latency.
    m_led = 4'd1;
    sb_q.push_back({m_led, m_lvl});
    usr_btn = 4'b0010;
    lat = 0;
    while (led_count == '0 && lat < DEB + 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("press_latency_in_range", int'(lat >= DEB + 2 && lat <= DEB + 4), 1);
    repeat (DEB + 20 - lat) @(negedge clk);
    usr_btn = '0;
    repeat (DEB + 20) @(negedge clk);
    checkNext("up1");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0010, DEB + 20);
      checkNext("up");
    end
    measureWindow(hi, on, off);
    checkOutput("lvl4_pwm_high", hi, PER);
    checkOutput("lvl4_usr_led_on", on, PER);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0010, DEB + 20);
      checkNext("up_sat");
    end
    applyStimulus(4'b0001, DEB + 20);
    checkNext("down_after_sat");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'b0001, DEB + 20);
      checkNext("down_sat");
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0010, DEB + 20);
      checkNext("up_again");
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100, DEB + 20);
      checkNext("dim");
    end
    repeat (PER) @(negedge clk);
    measureWindow(hi, on, off);
    checkOutput("lvl0_pwm_high", hi, 10);
    checkOutput("lvl0_usr_led_on", on, 10);
    checkOutput("lvl0_usr_led_off", off, PER - 10);

    applyStimulus(4'b0010, DEB - 10);
    checkNext("glitch");
    applyStimulus(4'b0011, 400);
    checkNext("up_down_both");

    applyStimulus(4'b1000, DEB + 20);
    checkNext("bright_to_1");
    repeat (PER) @(negedge clk);
    g = 0;
    while (pwm_out && g < 400) begin @(negedge clk); g++; end
    while (!pwm_out && g < 800) begin @(negedge clk); g++; end
    hi = 0;
    while (pwm_out && hi < 400) begin @(negedge clk); hi++; end
    checkOutput("lvl1_high_run", hi, 50);
    // At this negedge the counter reads 51; offset the press so the level change lands at count 60.
    k = (((10 - DEB - 3) % PER) + PER) % PER;
    repeat (k) @(negedge clk);
    m_lvl = 2;
    sb_q.push_back({m_led, m_lvl});
    usr_btn = 4'b1000;
    waitLevelChange(DEB + 20, cyc, ok);
    checkOutput("mid_change_seen", int'(ok), 1);
    g = 0;
    while (!pwm_out && g < 300) begin @(negedge clk); g++; end
    checkOutput("mid_no_runt_gap_ok", int'(g >= 130 && g <= 150), 1);
    hi = 0;
    while (pwm_out && hi < 300) begin @(negedge clk); hi++; end
    checkOutput("lvl2_high_run", hi, 100);
    usr_btn = '0;
    repeat (DEB + 20) @(negedge clk);
    checkNext("bright_mid");

`ifdef LED_BREATHE_EN
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0100, DEB + 20);
      checkNext("dim_pre_breathe");
    end
    breathe = 1'b1;
    fork
      begin
        repeat (50) @(negedge clk);
        usr_btn = 4'b0100;
        repeat (DEB + 20) @(negedge clk);
        usr_btn = '0;
      end
      begin
        int exp_seq[6];
        exp_seq = '{1, 2, 3, 4, 3, 2};
        for (int i = 0; i < 6; i++) begin
          waitLevelChange(600, cyc, ok);
          checkOutput("breathe_step_seen", int'(ok), 1);
          checkOutput("breathe_level", int'(duty_level), exp_seq[i]);
          if (i > 0) checkOutput("breathe_interval", cyc, 2 * PER);
        end
      end
    join
    breathe = 1'b0;
    m_lvl = 2;
    repeat (1000) @(negedge clk);
    checkOutput("breathe_off_hold", int'(duty_level), 2);
    applyStimulus(4'b0100, DEB + 20);
    checkNext("dim_after_breathe");
`endif

    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    checkOutput("midrst_led", int'(led_count), 0);
    checkOutput("midrst_lvl", int'(duty_level), NLEV - 1);
    checkOutput("midrst_pwm", int'(pwm_out), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    m_led = '0;
    m_lvl = LW'(NLEV - 1);
    @(negedge clk);
    measureWindow(hi, on, off);
    checkOutput("post_rst_pwm_high", hi, PER);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pwm_dimmer.md
Name: led_pwm_dimmer

Overview:
- Parametrised N-channel LED dimmer driven by four pushbuttons.
- Each button has a proper stable-count debouncer and a press-edge detector.
- A saturating bit-pattern counter selects which LEDs are lit; a saturating duty-level index selects PWM brightness from a computed table.
- Sits between the board buttons and the user LEDs. Optional auto "breathing" mode ramps the duty level.

Parameters:
- N_LED, 4, LED channel count; width of the pattern counter.
- PWM_PERIOD, 200, clk cycles per PWM period (>=2).
- N_LEVELS, 5, number of duty levels (>=2).
- LVL_W, 3, width of duty_level; must satisfy 2^LVL_W >= N_LEVELS.
- MIN_HIGH, 10, high time of level 0, in cycles.
- DEBOUNCE_CYCLES, 150, consecutive stable samples required to accept a button change.
- BREATHE_STEP, 64, PWM periods per automatic level step (breathe mode only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-high reset (name kept for board compatibility)
- usr_btn  in  4  raw buttons: [0] count down, [1] count up, [2] dimmer, [3] brighter
- breathe  in  1  breathing-mode request; ignored unless LED_BREATHE_EN is defined
- usr_led  out  N_LED  led_count AND replicated pwm_out
- pwm_out  out  1  registered PWM waveform
- led_count  out  N_LED  current LED pattern counter
- duty_level  out  LVL_W  current duty-level index

Behaviour:
- Reset: reset_n is asynchronous, active-high; clock is clk. While reset_n=1:
  - led_count=0, duty_level=N_LEVELS-1, pwm_cnt=0.
  - Active high time = PWM_PERIOD; pwm_out=0; usr_led=0.
  - All debouncer state and mismatch counters cleared; stable state=0.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debouncer (per button):
  - The mismatch counter increments while the synced input differs from the stable state.
  - It clears on any sample equal to the stable state.
  - On reaching DEBOUNCE_CYCLES, the stable state flips and the counter clears.
  - A stable 0->1 flip emits a one-cycle press pulse. Pulses shorter than DEBOUNCE_CYCLES are rejected.
  - Press-to-update latency is DEBOUNCE_CYCLES+2 .. DEBOUNCE_CYCLES+4 clk edges. A held button produces exactly one event.
- led_count:
  - Up press: +1, saturating at 2^N_LED-1. Down press: -1, saturating at 0.
  - Up and down pulses in the same cycle: no change.
- duty_level:
  - Brighter press: +1, saturating at N_LEVELS-1. Dimmer press: -1, saturating at 0.
  - Both in the same cycle: no change.
- Duty table: high(0)=MIN_HIGH; high(i)=PWM_PERIOD*i/(N_LEVELS-1) for i>=1, integer division, computed at elaboration.
  - Defaults give 10, 50, 100, 150, 200.
- PWM:
  - pwm_cnt counts 0..PWM_PERIOD-1 and wraps.
  - pwm_out is registered as (pwm_cnt < active_high).
  - active_high reloads from high(duty_level) only when pwm_cnt==PWM_PERIOD-1, so a level change takes effect from the next period with no runt pulses.
  - high=PWM_PERIOD gives constant 1.
- usr_led: combinational AND of led_count with {N_LED{pwm_out}}.
- Reset mid-operation: all state returns to reset values immediately; the first period after release uses the full high time.

Optional Feature:
- Macro: LED_BREATHE_EN.
- Defined, breathe=1:
  - duty_level steps automatically every BREATHE_STEP PWM periods, in a triangle 0..N_LEVELS-1..0. The step is applied at a period boundary.
  - Direction reverses at each end: at the top it goes down, at the bottom it goes up.
  - Brighter/dimmer presses are ignored; count buttons still work.
  - On breathe 1->0, duty_level holds its current value and buttons resume control.
  - Direction and step counter reset to up/0 on entry.
- Not defined: the breathe port is unused and the behaviour is identical to breathe=0; no breathing logic is synthesised.

Test Plan:
- Reset, then 3 up presses -> led_count=3, usr_led=4'b0011 during pwm high and 0 during low; pwm_out constant 1 at level 4.
- 20 up presses, then 1 down -> led_count saturates at 15, then becomes 14; 16 further downs -> 0 and holds.
- 4 dimmer presses -> duty_level=0; pwm_out high exactly 10 of every 200 cycles; a fifth press leaves it at 0.
- usr_btn[1] glitch of DEBOUNCE_CYCLES-10 cycles -> led_count unchanged. Hold usr_btn[0] and usr_btn[1] together for 400 cycles -> no change.
- Brighter press landing at pwm_cnt=60 while at level 1 -> the current period keeps 50 high cycles; the next period has 100.
- LED_BREATHE_EN, breathe=1, BREATHE_STEP=2 -> level sequence 0,1,2,3,4,3,2 changes every 400 cycles; dimmer presses ignored; after breathe=0 the level holds.
